// File: rtl/desc_loader_pkg.sv
// Shared definitions for the descriptor loader: FSM encoding, target
// selector codes, bus timeout and 64-bit register constants.
package desc_loader_pkg;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StRdLo = 3'd1,
        StRdHi = 3'd2,
        StDone = 3'd3,
        StErr  = 3'd4
    } state_e;

    localparam logic [1:0] SelIdt = 2'd0;
    localparam logic [1:0] SelGdt = 2'd1;
    localparam logic [1:0] SelLdt = 2'd2;
    localparam logic [1:0] SelTr  = 2'd3;

    // Wait cycles tolerated per bus word before the transfer is abandoned.
    localparam logic [7:0] TimeoutCnt = 8'd255;

    localparam int unsigned RegBus64 = 64;
    localparam logic [RegBus64-1:0] ZeroDWord = {RegBus64{1'b0}};

endpackage

// File: rtl/desc_loader.sv
// Descriptor loader: fetches a 64-bit system descriptor as two 32-bit bus
// reads and presents it for one cycle on the selected IDT/GDT/LDT/TR output.
module desc_loader
    import desc_loader_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                req_i,
    input  logic [1:0]          sel_i,
    input  logic [31:0]         addr_i,
    output logic                mem_ce_o,
    output logic                mem_we_o,
    output logic [31:0]         mem_addr_o,
    input  logic                mem_ack_i,
    input  logic [31:0]         mem_data_i,
    output logic                stallreq_o,
    output logic [RegBus64-1:0] idt_o,
    output logic [RegBus64-1:0] gdt_o,
    output logic [RegBus64-1:0] ldt_o,
    output logic [RegBus64-1:0] tr_o,
    output logic                reg64_o,
    output logic                err_o
);

    state_e      state_q, state_d;
    logic [1:0]  sel_q, sel_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] hi_q, hi_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        timeout;
    logic        aligned;

    // Timeout is judged on the registered count so it wins over a late ack.
    assign timeout = (cnt_q == TimeoutCnt);
    assign aligned = (addr_i[1:0] == 2'b00);

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: flush overrides everything, timeout overrides ack
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_i) begin
                        state_d = aligned ? StRdLo : StErr;
                    end
                end
                StRdLo: begin
                    if (timeout) begin
                        state_d = StErr;
                    end else if (mem_ack_i) begin
                        state_d = StRdHi;
                    end
                end
                StRdHi: begin
                    if (timeout) begin
                        state_d = StErr;
                    end else if (mem_ack_i) begin
                        state_d = StDone;
                    end
                end
                StDone:  state_d = StIdle;
                StErr:   state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    // Datapath next-state: latch request, capture words, run the wait counter
    always_comb begin
        sel_d  = sel_q;
        addr_d = addr_q;
        lo_d   = lo_q;
        hi_d   = hi_q;
        cnt_d  = cnt_q;
        if (flush) begin
            lo_d  = '0;
            hi_d  = '0;
            cnt_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_i && aligned) begin
                        sel_d  = sel_i;
                        addr_d = addr_i;
                        lo_d   = '0;
                        hi_d   = '0;
                        cnt_d  = '0;
                    end
                end
                StRdLo: begin
                    if (!timeout) begin
                        if (mem_ack_i) begin
                            lo_d   = mem_data_i;
                            addr_d = addr_q + 32'd4;
                            cnt_d  = '0;
                        end else begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end
                end
                StRdHi: begin
                    if (!timeout) begin
                        if (mem_ack_i) begin
                            hi_d = mem_data_i;
                        end else begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q  <= SelIdt;
            addr_q <= '0;
            lo_q   <= '0;
            hi_q   <= '0;
            cnt_q  <= '0;
        end else begin
            sel_q  <= sel_d;
            addr_q <= addr_d;
            lo_q   <= lo_d;
            hi_q   <= hi_d;
            cnt_q  <= cnt_d;
        end
    end

    // FSM outputs: bus strobes, stall, and the one-cycle result/error pulses
    always_comb begin
        mem_ce_o   = (state_q == StRdLo) || (state_q == StRdHi);
        mem_we_o   = 1'b0;
        mem_addr_o = addr_q;
        stallreq_o = ((state_q == StIdle) && req_i) || mem_ce_o;
        reg64_o    = (state_q == StDone);
        err_o      = (state_q == StErr);
        idt_o      = ZeroDWord;
        gdt_o      = ZeroDWord;
        ldt_o      = ZeroDWord;
        tr_o       = ZeroDWord;
        if (state_q == StDone) begin
            unique case (sel_q)
                SelIdt: idt_o = {hi_q, lo_q};
                SelGdt: gdt_o = {hi_q, lo_q};
                SelLdt: ldt_o = {hi_q, lo_q};
                SelTr:  tr_o  = {hi_q, lo_q};
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_desc_loader.sv
// Self-checking bench for desc_loader: directed transfers feed a scoreboard
// of expected DONE/ERR pulses, checked by an independent output monitor.
module tb_desc_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        req_i;
    logic [1:0]  sel_i;
    logic [31:0] addr_i;
    logic        mem_ce_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [31:0] mem_data_i;
    logic        stallreq_o;
    logic [63:0] idt_o, gdt_o, ldt_o, tr_o;
    logic        reg64_o;
    logic        err_o;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        bit          is_err;
        logic [1:0]  sel;
        logic [63:0] data;
        int          cyc;
        string       tag;
    } exp_t;

    exp_t sb[$];

    desc_loader dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .req_i      (req_i),
        .sel_i      (sel_i),
        .addr_i     (addr_i),
        .mem_ce_o   (mem_ce_o),
        .mem_we_o   (mem_we_o),
        .mem_addr_o (mem_addr_o),
        .mem_ack_i  (mem_ack_i),
        .mem_data_i (mem_data_i),
        .stallreq_o (stallreq_o),
        .idt_o      (idt_o),
        .gdt_o      (gdt_o),
        .ldt_o      (ldt_o),
        .tr_o       (tr_o),
        .reg64_o    (reg64_o),
        .err_o      (err_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every result or error pulse must match the head of the scoreboard
    always @(negedge clk) begin
        if ((reg64_o === 1'b1) || (err_o === 1'b1)) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse: got reg64=%b err=%b at cycle %0d expected none",
                         reg64_o, err_o, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.tag, " cycle"}, 64'(cyc), 64'(e.cyc));
                check({e.tag, " reg64"}, 64'(reg64_o), 64'(!e.is_err));
                check({e.tag, " err"}, 64'(err_o), 64'(e.is_err));
                check({e.tag, " idt"}, idt_o, (!e.is_err && e.sel == 2'd0) ? e.data : 64'd0);
                check({e.tag, " gdt"}, gdt_o, (!e.is_err && e.sel == 2'd1) ? e.data : 64'd0);
                check({e.tag, " ldt"}, ldt_o, (!e.is_err && e.sel == 2'd2) ? e.data : 64'd0);
                check({e.tag, " tr"}, tr_o, (!e.is_err && e.sel == 2'd3) ? e.data : 64'd0);
            end
        end
    end

    // Full transfer with wlo/whi wait cycles before each ack.
    task automatic do_read(input logic [1:0] s, input logic [31:0] a, input logic [31:0] lo,
                           input logic [31:0] hi, input int wlo, input int whi,
                           input string tag);
        logic [31:0] a4;
        exp_t        e;
        a4       = a + 32'd4;
        e.is_err = 1'b0;
        e.sel    = s;
        e.data   = {hi, lo};
        e.cyc    = cyc + 3 + wlo + whi;
        e.tag    = tag;
        sb.push_back(e);
        req_i     = 1'b1;
        sel_i     = s;
        addr_i    = a;
        mem_ack_i = 1'b0;
        #1;
        check({tag, " idle_stall"}, 64'(stallreq_o), 64'd1);
        check({tag, " idle_ce"}, 64'(mem_ce_o), 64'd0);
        tick();
        for (int i = 0; i < wlo; i++) begin
            check({tag, " lo_wait_ce"}, 64'(mem_ce_o), 64'd1);
            tick();
        end
        mem_ack_i  = 1'b1;
        mem_data_i = lo;
        #1;
        check({tag, " lo_ce"}, 64'(mem_ce_o), 64'd1);
        check({tag, " lo_addr"}, 64'(mem_addr_o), 64'(a));
        check({tag, " lo_stall"}, 64'(stallreq_o), 64'd1);
        tick();
        mem_ack_i  = 1'b0;
        mem_data_i = 32'd0;
        for (int i = 0; i < whi; i++) begin
            check({tag, " hi_wait_ce"}, 64'(mem_ce_o), 64'd1);
            tick();
        end
        mem_ack_i  = 1'b1;
        mem_data_i = hi;
        #1;
        check({tag, " hi_addr"}, 64'(mem_addr_o), 64'(a4));
        check({tag, " hi_stall"}, 64'(stallreq_o), 64'd1);
        tick();
        // DONE cycle: req still high but stall must be released
        mem_ack_i  = 1'b0;
        mem_data_i = 32'd0;
        #1;
        check({tag, " done_stall"}, 64'(stallreq_o), 64'd0);
        check({tag, " done_ce"}, 64'(mem_ce_o), 64'd0);
        tick();
        req_i = 1'b0;
    endtask

    initial begin
        exp_t e;
        int   c0;
        bit   seen;

        rst        = 1'b1;
        flush      = 1'b0;
        req_i      = 1'b0;
        sel_i      = 2'd0;
        addr_i     = 32'd0;
        mem_ack_i  = 1'b0;
        mem_data_i = 32'd0;
        repeat (3) tick();
        check("rst_ce", 64'(mem_ce_o), 64'd0);
        check("rst_we", 64'(mem_we_o), 64'd0);
        check("rst_addr", 64'(mem_addr_o), 64'd0);
        check("rst_reg64", 64'(reg64_o), 64'd0);
        check("rst_err", 64'(err_o), 64'd0);
        check("rst_gdt", gdt_o, 64'd0);
        rst = 1'b0;
        tick();

        // Directed transfers
        do_read(2'd1, 32'h0000_1000, 32'h1111_2222, 32'h3333_4444, 0, 0, "gdt_zero_wait");
        do_read(2'd3, 32'hFFFF_FFFC, 32'hDEAD_BEEF, 32'hCAFE_F00D, 2, 2, "tr_wrap");
        do_read(2'd0, 32'h0000_0800, 32'h0000_00FF, 32'h00CF_9A00, 1, 0, "idt_wait");
        do_read(2'd2, 32'h1234_5678, 32'hA5A5_5A5A, 32'h0F0F_F0F0, 0, 3, "ldt_wait");

        // Misaligned address: one-cycle error, no bus access
        e.is_err = 1'b1; e.sel = 2'd0; e.data = 64'd0; e.cyc = cyc + 1; e.tag = "misalign";
        sb.push_back(e);
        req_i  = 1'b1;
        sel_i  = 2'd1;
        addr_i = 32'h0000_1002;
        #1;
        check("misalign_idle_ce", 64'(mem_ce_o), 64'd0);
        tick();
        check("misalign_err_ce", 64'(mem_ce_o), 64'd0);
        check("misalign_err_stall", 64'(stallreq_o), 64'd0);
        req_i = 1'b0;
        tick();
        check("misalign_after_ce", 64'(mem_ce_o), 64'd0);

        // Ack while idle is ignored
        mem_ack_i = 1'b1;
        tick();
        check("idle_ack_ce", 64'(mem_ce_o), 64'd0);
        tick();
        mem_ack_i = 1'b0;

        // Timeout in RD_LO; an ack on the timeout cycle must lose to the error
        c0 = cyc;
        e.is_err = 1'b1; e.sel = 2'd0; e.data = 64'd0; e.cyc = c0 + 257; e.tag = "timeout";
        sb.push_back(e);
        req_i  = 1'b1;
        sel_i  = 2'd2;
        addr_i = 32'h0000_2000;
        seen   = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            tick();
            mem_ack_i = (cyc == c0 + 256);
            if (err_o === 1'b1) seen = 1'b1;
        end
        check("timeout_seen", 64'(seen), 64'd1);
        mem_ack_i = 1'b0;
        req_i     = 1'b0;
        tick();
        check("timeout_idle_ce", 64'(mem_ce_o), 64'd0);
        check("timeout_idle_stall", 64'(stallreq_o), 64'd0);
        do_read(2'd1, 32'h0000_3000, 32'h5555_6666, 32'h7777_8888, 0, 1, "after_timeout");

        // Flush in RD_HI with a simultaneous ack: no result pulse
        req_i  = 1'b1;
        sel_i  = 2'd0;
        addr_i = 32'h0000_4000;
        tick();
        mem_ack_i  = 1'b1;
        mem_data_i = 32'h0102_0304;
        tick();
        flush      = 1'b1;
        mem_data_i = 32'h0506_0708;
        tick();
        flush     = 1'b0;
        mem_ack_i = 1'b0;
        req_i     = 1'b0;
        #1;
        check("flush_ce", 64'(mem_ce_o), 64'd0);
        check("flush_reg64", 64'(reg64_o), 64'd0);
        check("flush_stall", 64'(stallreq_o), 64'd0);
        repeat (3) tick();

        // Reset in the middle of RD_LO
        req_i  = 1'b1;
        sel_i  = 2'd1;
        addr_i = 32'h0000_5000;
        tick();
        check("midrst_ce_before", 64'(mem_ce_o), 64'd1);
        rst   = 1'b1;
        req_i = 1'b0;
        tick();
        check("midrst_ce", 64'(mem_ce_o), 64'd0);
        check("midrst_addr", 64'(mem_addr_o), 64'd0);
        check("midrst_stall", 64'(stallreq_o), 64'd0);
        check("midrst_reg64", 64'(reg64_o), 64'd0);
        rst = 1'b0;
        repeat (3) tick();
        check("midrst_err", 64'(err_o), 64'd0);

        do_read(2'd2, 32'h0000_6000, 32'h9999_AAAA, 32'hBBBB_CCCC, 0, 0, "after_reset");
        repeat (3) tick();
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
